// File: rtl/regfile_nport_if.sv
// Register-file port bundle: one write port, NRD flattened read ports, PC alias and PC-write notification.
interface regfile_nport_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NRD   = 3
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH-1:0]     wdata;
    logic [NRD*AW-1:0]    ra;
    logic                 rd_en;
    logic [WIDTH-1:0]     pc_in;
    logic [NRD*WIDTH-1:0] rd;
    logic                 rd_valid;
    logic                 pc_wr;
    logic [WIDTH-1:0]     pc_wdata;

    modport master (
        output we, waddr, wdata, ra, rd_en, pc_in,
        input  rd, rd_valid, pc_wr, pc_wdata
    );

    modport slave (
        input  we, waddr, wdata, ra, rd_en, pc_in,
        output rd, rd_valid, pc_wr, pc_wdata
    );
endinterface

// File: rtl/regfile_nport.sv
// N-read / 1-write register file with registered read data and a PC-aliased top address.
// Define REGFILE_BYPASS_EN for write-through forwarding; default is read-before-write.
module regfile_nport #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NRD   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_nport_if.slave  bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] PC_ADDR = AW'(DEPTH - 1);

    // Entry DEPTH-1 is never written, so it stays at its reset value and is trimmed.
    logic [WIDTH-1:0]     regs [DEPTH];
    logic [NRD*WIDTH-1:0] rd_next_c;
    logic                 wr_store_c;
    logic                 wr_pc_c;

    assign wr_store_c = bus.we && (bus.waddr != PC_ADDR);
    assign wr_pc_c    = bus.we && (bus.waddr == PC_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                regs[j] <= '0;
            end
        end else if (wr_store_c) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_port
        logic [AW-1:0]    addr_c;
        logic [WIDTH-1:0] sel_c;

        assign addr_c = bus.ra[i*AW +: AW];

        always_comb begin
            sel_c = '0;
            if (addr_c == PC_ADDR) begin
                sel_c = bus.pc_in;
            end else begin
                sel_c = regs[addr_c];
`ifdef REGFILE_BYPASS_EN
                if (wr_store_c && (bus.waddr == addr_c)) begin
                    sel_c = bus.wdata;
                end
`endif
            end
        end

        assign rd_next_c[i*WIDTH +: WIDTH] = sel_c;
    end

    // Read capture; rd_en low holds the previous data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd       <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd <= rd_next_c;
            end
        end
    end

    // Writes to the PC alias are handed off to the fetch logic as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc_wr    <= 1'b0;
            bus.pc_wdata <= '0;
        end else begin
            bus.pc_wr <= wr_pc_c;
            if (wr_pc_c) begin
                bus.pc_wdata <= bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_regfile_nport.sv
// Randomised and directed bench for regfile_nport against an array-based reference model.
module tb_regfile_nport;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 16;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned WB  = 8;
    localparam int unsigned DB  = 8;
    localparam int unsigned NB  = 4;
    localparam int unsigned AWB = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_nport_if #(.WIDTH(W),  .DEPTH(D),  .NRD(N))  bus_a();
    regfile_nport_if #(.WIDTH(WB), .DEPTH(DB), .NRD(NB)) bus_b();

    regfile_nport #(.WIDTH(W),  .DEPTH(D),  .NRD(N))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    regfile_nport #(.WIDTH(WB), .DEPTH(DB), .NRD(NB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  mem_a [D-1];
    logic [W-1:0]  exp_rd_a [N];
    logic          exp_valid_a;
    logic          exp_pcwr_a;
    logic [W-1:0]  exp_pcwd_a;
    logic [WB-1:0] mem_b [DB-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < int'(D) - 1; j++) mem_a[j] = '0;
        for (int i = 0; i < int'(N); i++) exp_rd_a[i] = '0;
        exp_valid_a = 1'b0;
        exp_pcwr_a  = 1'b0;
        exp_pcwd_a  = '0;
    endtask

    function automatic logic [AW-1:0] port_addr(input int i);
        logic [N*AW-1:0] ra;
        ra = bus_a.ra;
        return ra[i*AW +: AW];
    endfunction

    task automatic check_outputs_a(input string tag);
        logic [N*W-1:0] rd;
        rd = bus_a.rd;
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("%s_rd%0d", tag, i), 64'(rd[i*W +: W]), 64'(exp_rd_a[i]));
        end
        check({tag, "_valid"}, 64'(bus_a.rd_valid), 64'(exp_valid_a));
        check({tag, "_pcwr"},  64'(bus_a.pc_wr),    64'(exp_pcwr_a));
        check({tag, "_pcwd"},  64'(bus_a.pc_wdata), 64'(exp_pcwd_a));
    endtask

    // Apply the current bus_a inputs for one edge, advance the model, compare.
    task automatic step_a(input string tag);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(N); i++) begin
            a = port_addr(i);
            if (bus_a.rd_en) begin
                if (int'(a) == int'(D) - 1)
                    exp_rd_a[i] = bus_a.pc_in;
                else if (BYPASS && bus_a.we && bus_a.waddr == a)
                    exp_rd_a[i] = bus_a.wdata;
                else
                    exp_rd_a[i] = mem_a[a];
            end
        end
        exp_valid_a = bus_a.rd_en;
        exp_pcwr_a  = bus_a.we && (int'(bus_a.waddr) == int'(D) - 1);
        if (exp_pcwr_a) exp_pcwd_a = bus_a.wdata;
        if (bus_a.we && int'(bus_a.waddr) < int'(D) - 1) mem_a[bus_a.waddr] = bus_a.wdata;
        @(posedge clk);
        #1;
        check_outputs_a(tag);
    endtask

    task automatic idle_a();
        bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0;
        bus_a.ra = '0; bus_a.rd_en = 1'b0; bus_a.pc_in = '0;
    endtask

    task automatic write_a(input int addr, input logic [W-1:0] data);
        bus_a.we = 1'b1; bus_a.waddr = AW'(addr); bus_a.wdata = data;
    endtask

    logic [N*W-1:0]   rd_snap;
    logic [NB*WB-1:0] rdb_snap;
    logic [NB*AWB-1:0] rab;
    logic [WB-1:0]    expb;
    int               ab;

    initial begin
        idle_a();
        bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0;
        bus_b.ra = '0; bus_b.rd_en = 1'b0; bus_b.pc_in = '0;
        model_reset();

        // Reset state
        #12;
        check_outputs_a("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read: ports read {5,5,0}
        write_a(5, 32'hDEADBEEF);
        step_a("wr5");
        idle_a();
        bus_a.ra = {4'd0, 4'd5, 4'd5};
        bus_a.rd_en = 1'b1;
        step_a("rd5");
        rd_snap = bus_a.rd;
        check("basic_p0", 64'(rd_snap[31:0]),  64'h0000_0000_DEAD_BEEF);
        check("basic_p1", 64'(rd_snap[63:32]), 64'h0000_0000_DEAD_BEEF);
        check("basic_p2", 64'(rd_snap[95:64]), 64'h0);

        // PC alias read, PC write pulse, then alias still reads pc_in
        idle_a();
        bus_a.pc_in = 32'h0000_0108; bus_a.ra = {4'd0, 4'd0, 4'd15}; bus_a.rd_en = 1'b1;
        step_a("pcrd");
        rd_snap = bus_a.rd;
        check("pc_alias", 64'(rd_snap[31:0]), 64'h108);
        idle_a();
        write_a(15, 32'h200);
        step_a("pcwr");
        check("pcwr_pulse", 64'(bus_a.pc_wr), 64'h1);
        check("pcwr_data",  64'(bus_a.pc_wdata), 64'h200);
        idle_a();
        bus_a.pc_in = 32'h0000_010C; bus_a.ra = {4'd0, 4'd0, 4'd15}; bus_a.rd_en = 1'b1;
        step_a("pcrd2");
        rd_snap = bus_a.rd;
        check("pcwr_end",  64'(bus_a.pc_wr), 64'h0);
        check("pc_alias2", 64'(rd_snap[31:0]), 64'h10C);

        // Same-cycle write/read hazard on reg 2
        idle_a();
        write_a(2, 32'h11);
        step_a("hz0");
        write_a(2, 32'h22);
        bus_a.ra = {4'd0, 4'd2, 4'd0}; bus_a.rd_en = 1'b1;
        step_a("hz1");
        rd_snap = bus_a.rd;
        check("hazard", 64'(rd_snap[63:32]), BYPASS ? 64'h22 : 64'h11);
        idle_a();
        bus_a.ra = {4'd0, 4'd2, 4'd0}; bus_a.rd_en = 1'b1;
        step_a("hz2");
        rd_snap = bus_a.rd;
        check("hazard_next", 64'(rd_snap[63:32]), 64'h22);

        // Stall with concurrent write
        idle_a();
        write_a(4, 32'hA);
        step_a("st0");
        idle_a();
        bus_a.ra = {4'd4, 4'd4, 4'd4}; bus_a.rd_en = 1'b1;
        step_a("st1");
        for (int k = 0; k < 3; k++) begin
            write_a(4, 32'hB);
            bus_a.rd_en = 1'b0;
            step_a("stall");
            rd_snap = bus_a.rd;
            check("stall_hold", 64'(rd_snap[31:0]), 64'hA);
            check("stall_valid", 64'(bus_a.rd_valid), 64'h0);
        end
        idle_a();
        bus_a.ra = {4'd4, 4'd4, 4'd4}; bus_a.rd_en = 1'b1;
        step_a("st2");
        rd_snap = bus_a.rd;
        check("stall_new", 64'(rd_snap[31:0]), 64'hB);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bus_a.we    = 1'($urandom_range(0, 1));
            bus_a.waddr = AW'($urandom_range(0, D - 1));
            bus_a.wdata = W'($urandom);
            bus_a.ra    = (N*AW)'($urandom);
            bus_a.rd_en = ($urandom_range(0, 3) != 0);
            bus_a.pc_in = W'($urandom);
            if ($urandom_range(0, 3) == 0) bus_a.ra[AW-1:0] = bus_a.waddr;
            step_a("rnd");
        end

        // Asynchronous mid-run reset with a pending write
        write_a(3, 32'h1234_5678);
        step_a("prerst");
        write_a(3, 32'hFFFF_FFFF);
        bus_a.rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs_a("async_rst");
        @(posedge clk);
        #1;
        check_outputs_a("rst_hold");
        rst_n = 1'b1;
        idle_a();
        bus_a.ra = {4'd0, 4'd0, 4'd3}; bus_a.rd_en = 1'b1;
        step_a("postrst");
        rd_snap = bus_a.rd;
        check("postrst_r3", 64'(rd_snap[31:0]), 64'h0);
        idle_a();

        // Parameter sweep instance: WIDTH=8, DEPTH=8, NRD=4
        for (int j = 0; j < int'(DB) - 1; j++) begin
            mem_b[j] = WB'(j * 37 + 5);
            bus_b.we = 1'b1; bus_b.waddr = AWB'(j); bus_b.wdata = mem_b[j];
            @(posedge clk);
            #1;
        end
        bus_b.we = 1'b0;
        for (int k = 0; k < int'(DB); k++) begin
            rab = '0;
            for (int i = 0; i < int'(NB); i++) rab[i*AWB +: AWB] = AWB'((k + i) % int'(DB));
            bus_b.ra = rab;
            bus_b.pc_in = WB'(8'hC0 + k);
            bus_b.rd_en = 1'b1;
            @(posedge clk);
            #1;
            rdb_snap = bus_b.rd;
            for (int i = 0; i < int'(NB); i++) begin
                ab = (k + i) % int'(DB);
                expb = (ab == int'(DB) - 1) ? WB'(8'hC0 + k) : mem_b[ab];
                check($sformatf("sweep_k%0d_p%0d", k, i), 64'(rdb_snap[i*WB +: WB]), 64'(expb));
            end
            check("sweep_valid", 64'(bus_b.rd_valid), 64'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_nport.md
Name: regfile_nport

Overview:
- Parametrised successor to the combinational 16:1 register-select mux. Integrates register storage, N independent read ports, one write port and a PC-aliased top register.
- Read data is registered: one-cycle latency, with a stall/enable.
- Sits between decode and execute in the ARMv4 datapath. Replaces the storage array plus per-port mux instances.

Parameters:
- WIDTH, 32, data width of each register and of each port.
- DEPTH, 16, number of architectural registers; must be a power of two, ≥ 2.
- NRD, 3, number of read ports.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- ra  in  NRD*AW  read addresses, flattened; port i uses bits [i*AW +: AW].
- rd_en  in  1  read-capture enable; 0 = stall (hold outputs).
- pc_in  in  WIDTH  PC value (already +8 adjusted) returned for reads of address DEPTH-1.
- rd  out  NRD*WIDTH  registered read data, flattened; port i uses bits [i*WIDTH +: WIDTH].
- rd_valid  out  1  high the cycle after an rd_en capture.
- pc_wr  out  1  one-cycle pulse: a write to address DEPTH-1 was accepted.
- pc_wdata  out  WIDTH  data of that write, valid while pc_wr=1.

Behaviour:
- Reset (rst_n=0, asynchronous): all DEPTH-1 storage registers, rd, rd_valid, pc_wr and pc_wdata clear to 0 immediately and stay 0 until rst_n returns to 1. A reset mid-stall or mid-write discards the pending operation; no write completes on the edge where rst_n is low.
- Storage: registers 0..DEPTH-2 are flops. Address DEPTH-1 has no storage.
- Write: on a rising edge with we=1 and waddr<DEPTH-1, reg[waddr] <= wdata.
- PC write: we=1 with waddr=DEPTH-1 leaves storage unchanged. Next cycle pc_wr=1 and pc_wdata=wdata. Otherwise pc_wr=0 and pc_wdata holds its last value.
- Read select, per port i, combinational:
  - ra_i=DEPTH-1 selects pc_in (sampled at the capture edge).
  - Otherwise selects reg[ra_i].
- Read capture: on a rising edge with rd_en=1, every rd_i <= selected value. With rd_en=0, rd holds.
- Latency: exactly 1 cycle from address/rd_en to rd.
- rd_valid <= rd_en each edge.
- Simultaneous write and read of the same address (ra_i=waddr<DEPTH-1, we=1, rd_en=1): result depends on the optional feature below.
- Multiple ports reading the same address all return identical data. No port-count limit on aliasing.
- Out-of-range addresses cannot occur (DEPTH is a power of two).
- Stall with a concurrent write: the write still completes. The held rd is not refreshed. The next capture returns the new value.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. In the same-address case, rd_i captures wdata (the new value). Forwarding never applies to address DEPTH-1; that address always returns pc_in.
- Undefined: read-before-write. rd_i captures the old reg[ra_i]; the new value is visible from the following capture. Storage and timing are otherwise identical.

Test Plan:
- Reset check: assert rst_n=0 mid-run after writes → rd=0, rd_valid=0, pc_wr=0 asynchronously. After release, read reg 3 → 0.
- Basic write/read: write reg 5=0xDEADBEEF, then next cycle ra={5,5,0}, rd_en=1 → one cycle later all of port0/port1 = 0xDEADBEEF, port2 = 0, rd_valid=1.
- PC alias: pc_in=0x00000108, ra0=15 → rd0=0x00000108. Write 0x200 to reg 15 → storage unchanged, pc_wr=1 for one cycle with pc_wdata=0x200, and a later ra0=15 still returns pc_in.
- Same-cycle hazard: reg 2 holds 0x11; write 0x22 to reg 2 while ra1=2, rd_en=1:
  - With REGFILE_BYPASS_EN → rd1=0x22.
  - Without → rd1=0x11, and the next capture gives 0x22.
- Stall: capture reg 4=0xA, then rd_en=0 for 3 cycles while writing reg 4=0xB → rd holds 0xA and rd_valid=0. On rd_en=1 → 0xB.
- Parameter sweep: WIDTH=8, DEPTH=8, NRD=4. Write distinct values to regs 0..6 and read all on four ports with rotated addresses → each port returns its addressed value; address 7 returns pc_in.
